// File: rtl/ddr_stream_writer.sv
// ddr_stream_writer: buffers a 32-bit word stream and writes it to the DDR3
// slave as INCR bursts (<= BURST_MAX beats), one outstanding burst at a time.
// Ports: clk, rstn (async, active low); cfg_start/cfg_addr/cfg_words start a
// job, busy/done/err report it; s_data/s_valid/s_ready is the word stream;
// MASTER_WR_ADDR_*, MASTER_WR_DATA_*/STRB, MASTER_WR_BACK_* are the slave's
// write address, data and response channels.
// Optional: define DDR_STREAM_WRITER_BOUNDARY_4K_EN to keep bursts inside
// one 4 KiB page.
module ddr_stream_writer #(
    parameter logic [3:0] WR_ID      = 4'h0,
    parameter int         FIFO_DEPTH = 512,
    parameter int         BURST_MAX  = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_start,
    input  logic [31:0] cfg_addr,
    input  logic [23:0] cfg_words,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [3:0]  MASTER_WR_ADDR_ID,
    output logic [31:0] MASTER_WR_ADDR,
    output logic [7:0]  MASTER_WR_ADDR_LEN,
    output logic [1:0]  MASTER_WR_ADDR_BURST,
    output logic        MASTER_WR_ADDR_VALID,
    input  logic        MASTER_WR_ADDR_READY,
    output logic [31:0] MASTER_WR_DATA,
    output logic [3:0]  MASTER_WR_STRB,
    output logic        MASTER_WR_DATA_LAST,
    output logic        MASTER_WR_DATA_VALID,
    input  logic        MASTER_WR_DATA_READY,
    input  logic [3:0]  MASTER_WR_BACK_ID,
    input  logic [1:0]  MASTER_WR_BACK_RESP,
    input  logic        MASTER_WR_BACK_VALID,
    output logic        MASTER_WR_BACK_READY
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, WAIT_FILL, ADDR, DATA, RESP, DONE
    } state_t;

    state_t      state;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [31:0] addr_r;
    logic [23:0] issue_rem, acc_rem;
    logic [8:0]  len_r, beat;
    logic [7:0]  len_m1;
    logic        addr_valid, busy_r, done_r, err_r;
    logic [24:0] lim;
    logic        push, pop, full, last, fill_ok, in_data;

    assign count   = wr_ptr - rd_ptr;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign s_ready = busy_r && !full && (acc_rem != '0);
    assign push    = s_valid && s_ready;
    assign in_data = state == DATA;
    assign pop     = in_data && MASTER_WR_DATA_READY;
    assign last    = beat == len_r - 9'd1;
    assign fill_ok = {{(24-AW){1'b0}}, count} >= lim;

`ifdef DDR_STREAM_WRITER_BOUNDARY_4K_EN
    logic [10:0] bnd;
    // words left before the next 4 KiB page: 1..1024
    assign bnd = 11'd1024 - {1'b0, addr_r[11:2]};
`endif

    always_comb begin
        lim = {1'b0, issue_rem};
        if (lim > 25'(BURST_MAX))
            lim = 25'(BURST_MAX);
`ifdef DDR_STREAM_WRITER_BOUNDARY_4K_EN
        if (lim > {14'd0, bnd})
            lim = {14'd0, bnd};
`endif
    end

    // storage is not reset; reset only flushes the pointers
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            addr_r     <= '0;
            issue_rem  <= '0;
            acc_rem    <= '0;
            len_r      <= '0;
            len_m1     <= '0;
            beat       <= '0;
            addr_valid <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (push) begin
                wr_ptr  <= wr_ptr + (AW+1)'(1);
                acc_rem <= acc_rem - 24'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (cfg_start) begin
                        err_r     <= 1'b0;
                        addr_r    <= cfg_addr & 32'hFFFF_FFFC;
                        issue_rem <= cfg_words;
                        acc_rem   <= cfg_words;
                        if (cfg_words == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= WAIT_FILL;
                        end
                    end
                end
                WAIT_FILL: begin
                    // whole burst buffered, so DATA can never underrun
                    if (fill_ok) begin
                        len_r      <= lim[8:0];
                        len_m1     <= lim[7:0] - 8'd1;
                        addr_valid <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (MASTER_WR_ADDR_READY) begin
                        addr_valid <= 1'b0;
                        beat       <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (MASTER_WR_DATA_READY) begin
                        beat <= beat + 9'd1;
                        if (last) begin
                            addr_r    <= addr_r + {21'd0, len_r, 2'b00};
                            issue_rem <= issue_rem - {15'd0, len_r};
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (MASTER_WR_BACK_VALID) begin
                        if (MASTER_WR_BACK_RESP != 2'b00 ||
                            MASTER_WR_BACK_ID != WR_ID)
                            err_r <= 1'b1;
                        if (issue_rem != '0) begin
                            state <= WAIT_FILL;
                        end else begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                 = busy_r;
    assign done                 = done_r;
    assign err                  = err_r;
    assign MASTER_WR_ADDR_ID    = WR_ID;
    assign MASTER_WR_ADDR       = addr_r;
    assign MASTER_WR_ADDR_LEN   = len_m1;
    assign MASTER_WR_ADDR_BURST = 2'b01;
    assign MASTER_WR_ADDR_VALID = addr_valid;
    assign MASTER_WR_DATA       = in_data ? mem[rd_ptr[AW-1:0]] : '0;
    assign MASTER_WR_STRB       = in_data ? 4'hF : 4'h0;
    assign MASTER_WR_DATA_LAST  = in_data && last;
    assign MASTER_WR_DATA_VALID = in_data;
    assign MASTER_WR_BACK_READY = state == RESP;

endmodule

// File: tb/tb_ddr_stream_writer.sv
// Bench for ddr_stream_writer: job table plus scoreboard queues for
// burst address/length, data beats and responses.
module tb_ddr_stream_writer;

    localparam logic [3:0] WR_ID = 4'h0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_addr = '0;
    logic [23:0] cfg_words = '0;
    logic        busy, done, err;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  a_id;
    logic [31:0] a_addr;
    logic [7:0]  a_len;
    logic [1:0]  a_burst;
    logic        a_valid;
    logic        a_ready = 1'b0;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last, w_valid;
    logic        w_ready = 1'b0;
    logic [3:0]  b_id = '0;
    logic [1:0]  b_resp = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;

    always #5 clk = ~clk;

    ddr_stream_writer #(
        .WR_ID(WR_ID), .FIFO_DEPTH(512), .BURST_MAX(256)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cfg_start(cfg_start), .cfg_addr(cfg_addr),
        .cfg_words(cfg_words),
        .busy(busy), .done(done), .err(err),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .MASTER_WR_ADDR_ID(a_id), .MASTER_WR_ADDR(a_addr),
        .MASTER_WR_ADDR_LEN(a_len), .MASTER_WR_ADDR_BURST(a_burst),
        .MASTER_WR_ADDR_VALID(a_valid),
        .MASTER_WR_ADDR_READY(a_ready),
        .MASTER_WR_DATA(w_data), .MASTER_WR_STRB(w_strb),
        .MASTER_WR_DATA_LAST(w_last),
        .MASTER_WR_DATA_VALID(w_valid),
        .MASTER_WR_DATA_READY(w_ready),
        .MASTER_WR_BACK_ID(b_id), .MASTER_WR_BACK_RESP(b_resp),
        .MASTER_WR_BACK_VALID(b_valid),
        .MASTER_WR_BACK_READY(b_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]       addr;
        logic [23:0]       words;
        logic [1:0]        resp;
        logic [3:0]        bid;
        logic [1:0]        nb;
        logic [2:0][31:0]  a;
        logic [2:0][8:0]   l;
        logic              exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic [31:0] addr, input logic [23:0] words,
        input logic [1:0] resp, input logic [3:0] bid,
        input logic [1:0] nb,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic [31:0] a2,
        input logic [8:0] l0, input logic [8:0] l1,
        input logic [8:0] l2, input logic e);
        vec_t v;
        v.addr = addr; v.words = words; v.resp = resp; v.bid = bid;
        v.nb = nb; v.exp_err = e;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.l[0] = l0; v.l[1] = l1; v.l[2] = l2;
        return v;
    endfunction

    function automatic logic [31:0] pat(input int j, input int i);
        return (32'(j) << 20) ^ 32'(i);
    endfunction

    logic [31:0] qa [$];
    logic [8:0]  ql [$];
    logic [5:0]  rq [$];
    logic [31:0] qd [$];
    int          nb_seen = 0;
    logic        in_burst = 1'b0;
    logic [8:0]  cur_len = '0;
    logic [8:0]  beat = '0;

    // slave model: outputs stay stable mid-cycle, so a handshake decided
    // at the falling edge is the one the DUT sees on the next rising edge
    always @(negedge clk) begin
        if (!rstn) begin
            a_ready = 1'b0;
            w_ready = 1'b0;
            b_valid = 1'b0;
        end else begin
            if (in_burst)
                chk("valid_hold", w_valid, 1'b1);
            if (b_valid) begin
                b_valid = 1'b0;
            end else if (b_ready && $urandom_range(0, 1) == 1) begin
                chk("resp_expected", rq.size() != 0, 1'b1);
                if (rq.size() != 0)
                    {b_resp, b_id} = rq.pop_front();
                b_valid = 1'b1;
            end
            a_ready = $urandom_range(0, 2) != 0;
            w_ready = $urandom_range(0, 3) != 0;
            if (a_valid && a_ready) begin
                chk("burst_expected", qa.size() != 0, 1'b1);
                if (qa.size() != 0) begin
                    cur_len = ql.pop_front();
                    chk("addr", a_addr, qa.pop_front());
                    chk("len", a_len, cur_len - 9'd1);
                end
                chk("id_burst", {a_id, a_burst}, {WR_ID, 2'b01});
                nb_seen++;
                in_burst = 1'b1;
                beat = '0;
            end
            if (w_valid && w_ready) begin
                chk("strb", w_strb, 4'hF);
                chk("beat_expected", qd.size() != 0, 1'b1);
                if (qd.size() != 0)
                    chk("data", w_data, qd.pop_front());
                chk("last", w_last, beat == cur_len - 9'd1);
                beat = beat + 9'd1;
                if (beat == cur_len)
                    in_burst = 1'b0;
            end
        end
    end

    task automatic stream(input int j, input int n);
        int i = 0;
        for (int c = 0; c < 20000 && i < n; c++) begin
            @(negedge clk);
            s_valid = $urandom_range(0, 3) != 0;
            s_data = pat(j, i);
            if (s_valid && s_ready) begin
                qd.push_back(s_data);
                i++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("stream_words", i, n);
    endtask

    task automatic run_job(input int j);
        vec_t v;
        int   n0;
        bit   seen;
        v = tv[j];
        for (int k = 0; k < int'(v.nb); k++) begin
            qa.push_back(v.a[k]);
            ql.push_back(v.l[k]);
            rq.push_back(k == 0 ? {v.resp, v.bid} : {2'b00, WR_ID});
        end
        n0 = nb_seen;
        @(negedge clk);
        cfg_addr = v.addr;
        cfg_words = v.words;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("busy_rise", busy, 1'b1);
        chk("err_cleared", err, 1'b0);
        fork
            stream(j, int'(v.words));
            begin
                seen = 0;
                for (int c = 0; c < 30000 && !seen; c++) begin
                    @(negedge clk);
                    if (done)
                        seen = 1;
                end
                chk("done_seen", seen, 1'b1);
                chk("busy_fall", busy, 1'b0);
            end
        join
        chk("err_at_done", err, v.exp_err);
        chk("burst_count", nb_seen - n0, v.nb);
        chk("data_left", qd.size(), 0);
        chk("burst_left", qa.size(), 0);
        chk("resp_left", rq.size(), 0);
    endtask

    function automatic logic [127:0] outs();
        return {busy, done, err, s_ready, a_valid, a_addr, a_len,
                a_burst, a_id, w_data, w_strb, w_last, w_valid, b_ready};
    endfunction

    localparam logic [89:0] RST_OUTS = {5'b0, 32'd0, 8'd0, 2'b01,
                                        WR_ID, 32'd0, 4'd0, 3'b0};

    initial begin
        bit seen;
        int n0;
        tv[0] = mk(32'h100, 8, 2'b00, WR_ID, 1, 32'h100, 0, 0,
                   8, 0, 0, 1'b0);
        tv[1] = mk(32'h0, 600, 2'b00, WR_ID, 3, 32'h0, 32'h400, 32'h800,
                   256, 256, 88, 1'b0);
`ifdef DDR_STREAM_WRITER_BOUNDARY_4K_EN
        tv[2] = mk(32'hFF0, 16, 2'b00, WR_ID, 2, 32'hFF0, 32'h1000, 0,
                   4, 12, 0, 1'b0);
        tv[5] = mk(32'hFFFF_FFF8, 4, 2'b00, WR_ID, 2, 32'hFFFF_FFF8,
                   32'h0, 0, 2, 2, 0, 1'b0);
`else
        tv[2] = mk(32'hFF0, 16, 2'b00, WR_ID, 1, 32'hFF0, 0, 0,
                   16, 0, 0, 1'b0);
        tv[5] = mk(32'hFFFF_FFF8, 4, 2'b00, WR_ID, 1, 32'hFFFF_FFF8,
                   0, 0, 4, 0, 0, 1'b0);
`endif
        tv[3] = mk(32'h203, 300, 2'b10, WR_ID, 2, 32'h200, 32'h600, 0,
                   256, 44, 0, 1'b1);
        tv[4] = mk(32'h1000, 3, 2'b00, WR_ID, 1, 32'h1000, 0, 0,
                   3, 0, 0, 1'b0);
        tv[6] = mk(32'h40, 2, 2'b00, 4'h3, 1, 32'h40, 0, 0,
                   2, 0, 0, 1'b1);

        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), {38'd0, RST_OUTS});
        rstn = 1'b1;

        n0 = nb_seen;
        @(negedge clk);
        cfg_addr = 32'h1234;
        cfg_words = 0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        @(negedge clk);
        chk("zero_done_end", done, 1'b0);
        chk("zero_traffic", {a_valid, w_valid, nb_seen != n0}, 3'b000);

        for (int j = 0; j < NV; j++)
            run_job(j);

        qa.push_back(32'h0);
        ql.push_back(9'd64);
        @(negedge clk);
        cfg_addr = 32'h0;
        cfg_words = 64;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (w_valid) begin
                seen = 1;
            end else begin
                s_valid = 1'b1;
                s_data = $urandom;
                if (s_ready)
                    qd.push_back(s_data);
            end
        end
        s_valid = 1'b0;
        chk("reached_data", seen, 1'b1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk("midburst_reset_outs", outs(), {38'd0, RST_OUTS});
        qa.delete();
        ql.delete();
        rq.delete();
        qd.delete();
        in_burst = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;

        run_job(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
